antirrebote_conmutadores: RTL and testbench

Input-conditioning stage between the four board slide switches (Gray-code input) and the Gray-to-binary decoder. It synchronises the raw asynchronous switch levels to clk and filters bounce so that only a code held stable for STABLE_CYCLES is forwarded. It issues a one-cycle strobe per accepted code change and flags illegal Gray transitions, where more than one bit changes between accepted codes.

---
 rtl/antirrebote_conmutadores_if.sv | 22 ++
 rtl/antirrebote_conmutadores.sv | 123 ++++++++++++
 tb/tb_antirrebote_conmutadores.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/antirrebote_conmutadores_if.sv
// Switch-side bundle for the debouncer: raw Gray input plus the conditioned outputs.
// master drives the raw switches, slave is the debouncer itself.
interface antirrebote_conmutadores_if #(
  parameter int N = 4
);
  logic [N-1:0] a;
  logic [N-1:0] gray_out;
  logic         cambio;
  logic         gray_err;
  logic [7:0]   err_cnt;
  logic         ocupado;

  modport master (
    output a,
    input  gray_out, cambio, gray_err, err_cnt, ocupado
  );

  modport slave (
    input  a,
    output gray_out, cambio, gray_err, err_cnt, ocupado
  );
endinterface

// File: rtl/antirrebote_conmutadores.sv
// Synchronises and debounces the Gray-coded slide switches, forwarding only codes
// that stay stable for STABLE_CYCLES, with a change strobe and illegal-jump flag.
module antirrebote_conmutadores #(
  parameter int N             = 4,
  parameter int STABLE_CYCLES = 1000000,
  parameter int CNT_W         = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  antirrebote_conmutadores_if.slave  bus
);

  typedef enum logic [0:0] {
    ESTABLE  = 1'b0,
    CONTANDO = 1'b1
  } state_t;

  localparam int              OW       = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     s1_q, s1_d;
  logic [N-1:0]     s2_q, s2_d;
  logic [N-1:0]     cand_q, cand_d;
  logic [N-1:0]     gray_q, gray_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cambio_q, cambio_d;
  logic             err_q, err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             ocupado_q, ocupado_d;
  logic [N-1:0]     diff;
  logic [OW-1:0]    ones;

  // Hamming distance between the candidate and the code currently forwarded
  always_comb begin
    diff = cand_q ^ gray_q;
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + OW'(diff[i]);
    end
  end

  always_comb begin
    s1_d      = bus.a;
    s2_d      = s1_q;
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    gray_d    = gray_q;
    cambio_d  = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      ESTABLE: begin
        if (s2_q != gray_q) begin
          cand_d  = s2_q;
          cnt_d   = '0;
          state_d = CONTANDO;
        end
      end
      CONTANDO: begin
        if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ESTABLE;
          // A bounce that settled back on the old code commits silently
          if (cand_q != gray_q) begin
            gray_d   = cand_q;
            cambio_d = 1'b1;
            if (ones > OW'(1)) begin
              err_d = 1'b1;
              if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
              end
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ESTABLE;
      end
    endcase

    ocupado_d = (state_d == CONTANDO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ESTABLE;
      s1_q      <= '0;
      s2_q      <= '0;
      cand_q    <= '0;
      gray_q    <= '0;
      cnt_q     <= '0;
      cambio_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      cand_q    <= cand_d;
      gray_q    <= gray_d;
      cnt_q     <= cnt_d;
      cambio_q  <= cambio_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.gray_out = gray_q;
  assign bus.cambio   = cambio_q;
  assign bus.gray_err = err_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.ocupado  = ocupado_q;

endmodule

// File: tb/tb_antirrebote_conmutadores.sv
// Directed bench for antirrebote_conmutadores with STABLE_CYCLES=8: a code applied
// just before edge 0 must appear on gray_out right after edge 10.
module tb_antirrebote_conmutadores;

  localparam int N  = 4;
  localparam int SC = 8;
  localparam int CW = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  antirrebote_conmutadores_if #(.N(N)) ifc ();

  antirrebote_conmutadores #(
    .N            (N),
    .STABLE_CYCLES(SC),
    .CNT_W        (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and park 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.a = 4'b0000;
    #3 reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (ifc.gray_out !== 4'b0000 || ifc.cambio !== 1'b0 || ifc.gray_err !== 1'b0 ||
        ifc.err_cnt !== 8'd0 || ifc.ocupado !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got gray_out=%b cambio=%b gray_err=%b err_cnt=%0d ocupado=%b, expected all 0",
               ifc.gray_out, ifc.cambio, ifc.gray_err, ifc.err_cnt, ifc.ocupado);
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_checks++;
      if (ifc.cambio !== 1'b0 || ifc.ocupado !== 1'b0 || ifc.gray_out !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL idle_after_reset cycle %0d: got cambio=%b ocupado=%b gray_out=%b, expected 0 0 0000",
                 i, ifc.cambio, ifc.ocupado, ifc.gray_out);
      end
    end
  endtask

  task automatic test_single_change();
    ifc.a = 4'b0001;
    for (int i = 0; i <= 9; i++) begin
      tick();
      n_checks++;
      if (ifc.gray_out !== 4'b0000 || ifc.cambio !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL single_early edge %0d: got gray_out=%b cambio=%b, expected 0000 0",
                 i, ifc.gray_out, ifc.cambio);
      end
    end
    tick();
    n_checks++;
    if (ifc.gray_out !== 4'b0001 || ifc.cambio !== 1'b1 || ifc.gray_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_commit: got gray_out=%b cambio=%b gray_err=%b, expected 0001 1 0",
               ifc.gray_out, ifc.cambio, ifc.gray_err);
    end
    tick();
    n_checks++;
    if (ifc.cambio !== 1'b0 || ifc.err_cnt !== 8'd0 || ifc.ocupado !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_after: got cambio=%b err_cnt=%0d ocupado=%b, expected 0 0 0",
               ifc.cambio, ifc.err_cnt, ifc.ocupado);
    end
  endtask

  task automatic test_bounce();
    int t;
    t = 0;
    for (int seg = 0; seg < 12; seg++) begin
      ifc.a = (seg % 2 == 0) ? 4'b0011 : 4'b0001;
      for (int k = 0; k < 3; k++) begin
        tick();
        t++;
        n_checks++;
        if (ifc.cambio !== 1'b0 || (t >= 3 && ifc.ocupado !== 1'b1)) begin
          n_fail++;
          $display("[TB] FAIL bounce tick %0d: got cambio=%b ocupado=%b, expected 0 1",
                   t, ifc.cambio, ifc.ocupado);
        end
      end
    end
    ifc.a = 4'b0011;
    for (int i = 0; i <= 9; i++) begin
      tick();
      n_checks++;
      if (ifc.gray_out !== 4'b0001 || ifc.cambio !== 1'b0 || ifc.ocupado !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL bounce_settle edge %0d: got gray_out=%b cambio=%b ocupado=%b, expected 0001 0 1",
                 i, ifc.gray_out, ifc.cambio, ifc.ocupado);
      end
    end
    tick();
    n_checks++;
    if (ifc.gray_out !== 4'b0011 || ifc.cambio !== 1'b1 || ifc.gray_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bounce_commit: got gray_out=%b cambio=%b gray_err=%b, expected 0011 1 0",
               ifc.gray_out, ifc.cambio, ifc.gray_err);
    end
    tick();
  endtask

  task automatic test_glitch_return();
    ifc.a = 4'b0111;
    repeat (5) tick();
    ifc.a = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (ifc.gray_out !== 4'b0011 || ifc.cambio !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL glitch tick %0d: got gray_out=%b cambio=%b, expected 0011 0",
                 i, ifc.gray_out, ifc.cambio);
      end
    end
    n_checks++;
    if (ifc.ocupado !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL glitch_idle: got ocupado=%b, expected 0", ifc.ocupado);
    end
  endtask

  task automatic test_illegal_jump();
    int exp_cnt;
    reset = 1'b0;
    ifc.a = 4'b0000;
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    ifc.a = 4'b0110;
    repeat (10) tick();
    tick();
    n_checks++;
    if (ifc.gray_out !== 4'b0110 || ifc.cambio !== 1'b1 || ifc.gray_err !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL jump_first: got gray_out=%b cambio=%b gray_err=%b, expected 0110 1 1",
               ifc.gray_out, ifc.cambio, ifc.gray_err);
    end
    tick();
    n_checks++;
    if (ifc.err_cnt !== 8'd1 || ifc.gray_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL jump_count1: got err_cnt=%0d gray_err=%b, expected 1 0",
               ifc.err_cnt, ifc.gray_err);
    end
    exp_cnt = 1;
    for (int k = 2; k <= 300; k++) begin
      ifc.a = (k % 2 == 1) ? 4'b0110 : 4'b0000;
      repeat (10) tick();
      tick();
      n_checks++;
      if (ifc.gray_err !== 1'b1 || ifc.cambio !== 1'b1 || ifc.gray_out !== ifc.a) begin
        n_fail++;
        $display("[TB] FAIL jump %0d pulse: got gray_err=%b cambio=%b gray_out=%b, expected 1 1 %b",
                 k, ifc.gray_err, ifc.cambio, ifc.gray_out, ifc.a);
      end
      if (exp_cnt < 255) exp_cnt++;
      tick();
      n_checks++;
      if (ifc.err_cnt !== 8'(exp_cnt)) begin
        n_fail++;
        $display("[TB] FAIL jump %0d err_cnt: got %0d, expected %0d", k, ifc.err_cnt, exp_cnt);
      end
    end
    n_checks++;
    if (ifc.err_cnt !== 8'd255) begin
      n_fail++;
      $display("[TB] FAIL err_cnt_saturated: got %0d, expected 255", ifc.err_cnt);
    end
  endtask

  task automatic test_reset_mid_count();
    ifc.a = 4'b1000;
    repeat (7) tick();
    n_checks++;
    if (ifc.ocupado !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midcount_busy: got ocupado=%b, expected 1", ifc.ocupado);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (ifc.gray_out !== 4'b0000 || ifc.ocupado !== 1'b0 || ifc.cambio !== 1'b0 ||
        ifc.err_cnt !== 8'd0) begin
      n_fail++;
      $display("[TB] FAIL midcount_async: got gray_out=%b ocupado=%b cambio=%b err_cnt=%0d, expected 0000 0 0 0",
               ifc.gray_out, ifc.ocupado, ifc.cambio, ifc.err_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ifc.gray_out !== 4'b0000) begin
        n_fail++;
        $display("[TB] FAIL midcount_held %0d: got gray_out=%b, expected 0000", i, ifc.gray_out);
      end
    end
    reset = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      tick();
      n_checks++;
      if (ifc.gray_out !== 4'b0000 || ifc.cambio !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL midcount_retime edge %0d: got gray_out=%b cambio=%b, expected 0000 0",
                 i, ifc.gray_out, ifc.cambio);
      end
    end
    tick();
    n_checks++;
    if (ifc.gray_out !== 4'b1000 || ifc.cambio !== 1'b1 || ifc.gray_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midcount_commit: got gray_out=%b cambio=%b gray_err=%b, expected 1000 1 0",
               ifc.gray_out, ifc.cambio, ifc.gray_err);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (ifc.cambio !== 1'b0 || ifc.gray_out !== 4'b1000) begin
        n_fail++;
        $display("[TB] FAIL midcount_single %0d: got cambio=%b gray_out=%b, expected 0 1000",
                 i, ifc.cambio, ifc.gray_out);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single_change();
    test_bounce();
    test_glitch_return();
    test_illegal_jump();
    test_reset_mid_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
